// File: rtl/nmi_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : nmi_arbiter_if
//  Description : Bundle of the event-source, CPU bus and ZX-Uno register
//                signals around the NMI arbiter. "master" is the system side
//                (event sources, CPU, register decoder); "slave" is the
//                arbiter itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nmi_arbiter_if #(
    parameter int NREQ = 4
);
    // ZX-Uno register port
    logic [7:0]      zxuno_addr;
    logic            zxuno_regrd;
    logic [7:0]      dout;
    logic            oe_n;

    // Event sources
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;

    // CPU bus observation and NMI / paging control
    logic [15:0]     a;
    logic            m1_n;
    logic            mreq_n;
    logic            rd_n;
    logic            nmiout_n;
    logic            page_configrom_active;

    modport master (
        output zxuno_addr,
        output zxuno_regrd,
        output req,
        output a,
        output m1_n,
        output mreq_n,
        output rd_n,
        input  dout,
        input  oe_n,
        input  nmiout_n,
        input  grant,
        input  page_configrom_active
    );

    modport slave (
        input  zxuno_addr,
        input  zxuno_regrd,
        input  req,
        input  a,
        input  m1_n,
        input  mreq_n,
        input  rd_n,
        output dout,
        output oe_n,
        output nmiout_n,
        output grant,
        output page_configrom_active
    );
endinterface
`default_nettype wire

// File: rtl/nmi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : nmi_arbiter
//  Description : Shares the Z80 NMI line between NREQ event sources. Each
//                rising edge on req[i] is latched as pending; one winner at a
//                time gets the NMI, the config ROM page, and is tracked from
//                the entry fetch at ENTRY_ADDR to the exit fetch at EXIT_ADDR.
//                The granted event is readable at ZX-Uno register REGADDR.
//                Optional macro NMIARB_ROUNDROBIN_EN selects round-robin
//                arbitration instead of fixed lowest-index priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module nmi_arbiter #(
    parameter int          NREQ        = 4,
    parameter logic [7:0]  REGADDR     = 8'h08,
    parameter logic [15:0] ENTRY_ADDR  = 16'h0066,
    parameter logic [15:0] EXIT_ADDR   = 16'h006A,
    parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
    input  logic         clk,
    input  logic         rst,
    nmi_arbiter_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ASSERT     = 3'd1,
        S_IN_HANDLER = 3'd2,
        S_EXITING    = 3'd3
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_req_d;
    logic [NREQ-1:0] r_pending;
    logic [NREQ-1:0] r_grant;
    logic            r_nmiout_n;
    logic            r_page;
    logic [15:0]     r_count;

    logic [NREQ-1:0] w_rise;
    logic [NREQ-1:0] w_winner_oh;
    logic [NREQ-1:0] w_clear;
    logic [IDXW-1:0] w_winner_idx;
    logic            w_any_pending;
    logic            w_ack;
    logic            w_exit_fetch;
    logic [7:0]      w_dout;

    // New events are rising edges only; req_d resets high so a level held
    // through reset is not mistaken for an event.
    assign w_rise        = bus.req & ~r_req_d;
    assign w_any_pending = |r_pending;

    // Acknowledge: the CPU's M1 fetch of the NMI vector.
    assign w_ack        = ~bus.mreq_n & ~bus.m1_n & (bus.a == ENTRY_ADDR);
    // Handler exit marker: opcode read at EXIT_ADDR.
    assign w_exit_fetch = ~bus.mreq_n & ~bus.m1_n & ~bus.rd_n & (bus.a == EXIT_ADDR);

`ifdef NMIARB_ROUNDROBIN_EN
    logic [IDXW-1:0] r_last_grant;

    // Round-robin pick: nearest pending index strictly after the last grant.
    // Scanned from farthest to nearest so the nearest match is written last;
    // the last-granted index itself is only reached after a full wrap.
    always_comb begin
        int idx;
        w_winner_idx = '0;
        idx          = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (r_pending[idx]) begin
                w_winner_idx = IDXW'(idx);
            end
        end
    end
`else
    // Fixed-priority pick: lowest pending index wins.
    always_comb begin
        w_winner_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_winner_idx = IDXW'(i);
            end
        end
    end
`endif

    // One-hot form of the winner, empty when nothing is pending.
    always_comb begin
        w_winner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_winner_oh[i] = w_any_pending && (w_winner_idx == IDXW'(i));
        end
    end

    // A request is consumed only in the cycle it is granted.
    assign w_clear = (r_state == S_IDLE) ? w_winner_oh : '0;

    // Pending latch: clear-on-grant first, then OR in new edges so an edge
    // coinciding with its own grant stays queued for a second service.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d   <= '1;
            r_pending <= '0;
        end else begin
            r_req_d   <= bus.req;
            r_pending <= (r_pending & ~w_clear) | w_rise;
        end
    end

    // Service FSM: grant, wait for vector fetch (with timeout), run handler,
    // release the page once the exit fetch's M1 cycle has ended.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_nmiout_n <= 1'b1;
            r_page     <= 1'b0;
            r_count    <= '0;
`ifdef NMIARB_ROUNDROBIN_EN
            r_last_grant <= IDXW'(NREQ - 1);
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_pending) begin
                        r_grant    <= w_winner_oh;
                        r_nmiout_n <= 1'b0;
                        r_page     <= 1'b1;
                        r_count    <= '0;
                        r_state    <= S_ASSERT;
`ifdef NMIARB_ROUNDROBIN_EN
                        r_last_grant <= w_winner_idx;
`endif
                    end
                end

                S_ASSERT: begin
                    if (w_ack) begin
                        r_nmiout_n <= 1'b1;
                        r_state    <= S_IN_HANDLER;
                    end else if (r_count == ACK_TIMEOUT - 16'd1) begin
                        // CPU never took the NMI: drop the event entirely.
                        r_nmiout_n <= 1'b1;
                        r_page     <= 1'b0;
                        r_grant    <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end

                S_IN_HANDLER: begin
                    if (w_exit_fetch) begin
                        r_state <= S_EXITING;
                    end
                end

                S_EXITING: begin
                    // Keep the ROM paged until the exit opcode fetch completes.
                    if (bus.m1_n) begin
                        r_page  <= 1'b0;
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_grant    <= '0;
                    r_nmiout_n <= 1'b1;
                    r_page     <= 1'b0;
                    r_count    <= '0;
                end
            endcase
        end
    end

    // Event register: grant one-hot, zero-extended to the 8-bit data bus.
    always_comb begin
        w_dout             = '0;
        w_dout[NREQ-1:0]   = r_grant;
    end

    assign bus.dout                  = w_dout;
    assign bus.oe_n                  = ~((bus.zxuno_addr == REGADDR) & bus.zxuno_regrd);
    assign bus.nmiout_n              = r_nmiout_n;
    assign bus.grant                 = r_grant;
    assign bus.page_configrom_active = r_page;

endmodule
`default_nettype wire

// File: doc/nmi_arbiter.md
Name: nmi_arbiter

Overview:
- Shares the single Z80 NMI line between up to NREQ independent event sources (keyboard hotkeys, DivMMC button, Multiface, debugger).
- Latches each source's request and picks one winner at a time. It then drives the NMI, pages the config ROM, and tracks the handler from the entry fetch at ENTRY_ADDR to the exit fetch at EXIT_ADDR.
- The winning event is readable through the ZX-Uno register port.
- Sits between event sources and CPU/memory paging logic.

Parameters:
- NREQ, 4, number of requesters (1..8).
- REGADDR, 8'h08, ZX-Uno register address of the event register.
- ENTRY_ADDR, 16'h0066, NMI vector; an M1 fetch here acknowledges the NMI.
- EXIT_ADDR, 16'h006A, opcode fetch address marking handler exit.
- ACK_TIMEOUT, 16'd50000, cycles to wait in ASSERT for the acknowledge (1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- zxuno_addr  in  8  selected ZX-Uno register.
- zxuno_regrd  in  1  register read strobe.
- req  in  NREQ  event requests, level; rising edge = new event.
- a  in  16  CPU address bus.
- m1_n  in  1  CPU M1.
- mreq_n  in  1  CPU MREQ.
- rd_n  in  1  CPU RD.
- dout  out  8  event register: grant one-hot, zero-extended to 8 bits.
- oe_n  out  1  low when zxuno_addr==REGADDR and zxuno_regrd==1 (combinational).
- nmiout_n  out  1  NMI to CPU, active-low.
- grant  out  NREQ  one-hot winner, held for the whole service.
- page_configrom_active  out  1  high while an NMI is in service.

Behaviour:
- Reset values: nmiout_n=1, page_configrom_active=0, grant=0, dout=0, pending=0, state=IDLE, timeout counter=0.
- The registered req_d resets to all ones, so a request held high through reset does not fire; only a fresh 0->1 edge counts.
- Pending latch:
  - pending[i] is set on a req[i] rising edge (req & ~req_d) in any state.
  - pending[i] is cleared only in the cycle in which i is granted.
  - If an edge on i coincides with i's grant, pending[i] remains set (queued for a second service).
- IDLE:
  - If pending != 0, select the winner (lowest index wins unless round-robin).
  - Registered effects next cycle: grant=onehot(winner), dout={0,onehot}, nmiout_n=0, page_configrom_active=1, counter=0, state=ASSERT.
  - Latency from the req edge to nmiout_n low is 2 cycles: edge register, then grant.
- ASSERT:
  - Acknowledge condition: mreq_n==0 && m1_n==0 && a==ENTRY_ADDR. On it, nmiout_n<=1 and state=IN_HANDLER.
  - Otherwise the counter increments.
  - If counter reaches ACK_TIMEOUT-1 without the acknowledge, abort: nmiout_n<=1, page_configrom_active<=0, grant<=0, dout<=0, state=IDLE. The event is dropped and not re-pended.
- IN_HANDLER: when mreq_n==0 && m1_n==0 && rd_n==0 && a==EXIT_ADDR, state=EXITING. Other fetches are ignored.
- EXITING: on the first cycle with m1_n==1, page_configrom_active<=0, grant<=0, dout<=0, state=IDLE.
- A queued request is granted no earlier than the cycle after IDLE is re-entered, so there is at least one cycle with nmiout_n high between services.
- Requests arriving during a service only set pending; they never preempt the current service.
- rst asserted in any state returns all registers to reset values in the next cycle. This includes mid-service: NMI is released and the page is dropped.
- An unused state encoding recovers to IDLE with outputs as in reset.

Optional Feature:
- Macro: NMIARB_ROUNDROBIN_EN.
- Defined: the winner is the first pending index strictly after the last granted index, wrapping modulo NREQ. last_grant resets to NREQ-1, so index 0 wins first after reset. last_grant updates on every grant, including grants that later time out.
- Undefined: fixed priority, lowest index wins; no last_grant register is synthesized.

Test Plan:
1. req[2] 0->1, then fetch at 0x0066, then M1 fetch at 0x006A, then m1_n=1 -> nmiout_n low 2 cycles after the edge; grant=4'b0100 and dout=8'h04 while in service; nmiout_n=1 the cycle after the 0x0066 fetch; page and dout return to 0 the cycle after m1_n rises.
2. req[1] and req[3] edges in the same cycle, fixed priority -> req[1] served first (dout=8'h02), then req[3] (dout=8'h08) after exit, with ≥1 cycle of nmiout_n high between the two NMIs.
3. With NMIARB_ROUNDROBIN_EN, all four requests pulsed repeatedly -> grant order 0,1,2,3,0; no index is starved.
4. req[0] edge with no 0x0066 fetch, ACK_TIMEOUT=16 -> nmiout_n low exactly 16 cycles, then page=0, grant=0, state IDLE; pending[0]=0.
5. rst pulsed while in IN_HANDLER -> next cycle nmiout_n=1, page=0, dout=0, pending=0; req held high through reset produces no NMI.
6. zxuno_addr=8'h08 with regrd=1 -> oe_n=0 in the same cycle; any other address -> oe_n=1.
